// File: rtl/uart_tx_ctrl_if.sv
// Byte-source / serial-line bundle for uart_tx_ctrl.
// The master is the byte source side; the slave is the controller itself.
interface uart_tx_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_in;
    logic                 valid;
    logic                 ready;
    logic                 tx;
    logic                 busy;
    logic                 done;
    logic                 baud_tick;

    modport master (
        output data_in, valid,
        input  ready, tx, busy, done, baud_tick
    );

    modport slave (
        input  data_in, valid,
        output ready, tx, busy, done, baud_tick
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: one frame (start, data LSB first, optional parity, stop)
// per accepted byte, with bit timing from an internal enable-style baud counter.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 650,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_ctrl_if.slave bus
);
    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic                 tx_r;
    logic                 ready_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 tick;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (PARITY == 2) ? ~(^d) : (^d);
    endfunction

    // Tick is decoded from registered state only, so it is never high in IDLE.
    assign tick = (state != S_IDLE) && (baud_cnt == BAUD_LAST);

    assign bus.tx        = tx_r;
    assign bus.ready     = ready_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.baud_tick = tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            tx_r     <= 1'b1;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (state != S_IDLE) begin
                baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    // Parity is taken from the byte as accepted, before any shifting.
                    if (bus.valid) begin
                        shift    <= bus.data_in;
                        par_bit  <= parity_of(bus.data_in);
                        bit_cnt  <= '0;
                        baud_cnt <= '0;
                        tx_r     <= 1'b0;
                        ready_r  <= 1'b0;
                        busy_r   <= 1'b1;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        tx_r  <= shift[0];
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            if (PARITY != 0) begin
                                tx_r  <= par_bit;
                                state <= S_PARITY;
                            end else begin
                                tx_r  <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            tx_r <= shift[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        tx_r  <= 1'b1;
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: directed frames are queued as expected bit
// sequences and per-lane line monitors decode and compare what appears on tx.
module tb_uart_tx_ctrl;
    typedef struct packed {
        logic [11:0] bits;   // bit k = k-th bit on the line (start first)
        logic [3:0]  nbits;
        logic [15:0] gap;    // required start-to-start spacing, 0 = don't care
    } frame_t;

    localparam int CPB_OF [4] = '{4, 4, 4, 650};

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    frame_t exp_q [4][$];

    logic [3:0] tx_w, ready_w, busy_w, done_w, baud_w;

    uart_tx_ctrl_if #(.DATA_BITS(8)) bus0 ();
    uart_tx_ctrl_if #(.DATA_BITS(8)) bus1 ();
    uart_tx_ctrl_if #(.DATA_BITS(8)) bus2 ();
    uart_tx_ctrl_if #(.DATA_BITS(8)) bus3 ();

    uart_tx_ctrl #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0)) u_none (.clk(clk), .rst(rst), .bus(bus0));
    uart_tx_ctrl #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1)) u_even (.clk(clk), .rst(rst), .bus(bus1));
    uart_tx_ctrl #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2)) u_odd  (.clk(clk), .rst(rst), .bus(bus2));
    uart_tx_ctrl u_dflt (.clk(clk), .rst(rst), .bus(bus3));

    assign tx_w    = {bus3.tx, bus2.tx, bus1.tx, bus0.tx};
    assign ready_w = {bus3.ready, bus2.ready, bus1.ready, bus0.ready};
    assign busy_w  = {bus3.busy, bus2.busy, bus1.busy, bus0.busy};
    assign done_w  = {bus3.done, bus2.done, bus1.done, bus0.done};
    assign baud_w  = {bus3.baud_tick, bus2.baud_tick, bus1.baud_tick, bus0.baud_tick};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got timeout/unexpected event, want expected DUT event", name);
    endtask

    function automatic frame_t mk(input logic [11:0] bits, input int n, input int gap);
        frame_t f;
        f.bits  = bits;
        f.nbits = 4'(n);
        f.gap   = 16'(gap);
        return f;
    endfunction

    task automatic drive(input int lane, input logic [7:0] d, input logic v);
        case (lane)
            0: begin bus0.data_in = d; bus0.valid = v; end
            1: begin bus1.data_in = d; bus1.valid = v; end
            2: begin bus2.data_in = d; bus2.valid = v; end
            default: begin bus3.data_in = d; bus3.valid = v; end
        endcase
    endtask

    task automatic wait_accept(input int lane, input string name);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ready_w[lane] === 1'b0) return;
        end
        fail_now(name);
    endtask

    task automatic wait_ready(input int lane, input string name);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ready_w[lane] === 1'b1) return;
        end
        fail_now(name);
    endtask

    task automatic wait_done(input int lane, input int exp_k, input int bound, input string name);
        for (int k = 1; k <= bound; k++) begin
            @(negedge clk);
            if (done_w[lane] === 1'b1) begin
                check(name, k, exp_k);
                return;
            end
        end
        fail_now(name);
    endtask

    // Line monitors: one per DUT, decoding frames from tx and checking them
    // against the front of that lane's expected queue.
    for (genvar g = 0; g < 4; g++) begin : g_mon
        initial begin : mon
            logic       prev, chk_low, have_last, aborted, seen_bad;
            int         last_start, ticks, cpb;
            frame_t     ef;
            logic [4:0] obs, want, smp, exp_s;
            cpb = CPB_OF[g];
            prev = 1'b1; chk_low = 1'b0; have_last = 1'b0; last_start = 0;
            obs = '0; want = '0;
            forever begin
                @(negedge clk);
                if (chk_low) begin
                    chk_low = 1'b0;
                    check($sformatf("lane%0d_done_one_cycle", g), 32'(done_w[g]), 32'd0);
                end
                if (rst) begin
                    prev = 1'b1;
                    continue;
                end
                if (prev === 1'b1 && tx_w[g] === 1'b0) begin
                    if (exp_q[g].size() == 0) begin
                        fail_now($sformatf("lane%0d_unexpected_frame", g));
                        prev = 1'b0;
                        continue;
                    end
                    ef = exp_q[g].pop_front();
                    if (ef.gap != 0 && have_last)
                        check($sformatf("lane%0d_start_gap", g), 32'(cyc - last_start), 32'(ef.gap));
                    last_start = cyc;
                    have_last = 1'b1;
                    ticks = 0;
                    aborted = 1'b0;
                    for (int b = 0; b < int'(ef.nbits); b++) begin
                        seen_bad = 1'b0;
                        for (int c = 0; c < cpb; c++) begin
                            if (b != 0 || c != 0) @(negedge clk);
                            if (rst) begin
                                aborted = 1'b1;
                                break;
                            end
                            smp   = {busy_w[g], ready_w[g], done_w[g], baud_w[g], tx_w[g]};
                            exp_s = {1'b1, 1'b0, 1'b0, (c == cpb - 1), ef.bits[b]};
                            if (baud_w[g] === 1'b1) ticks++;
                            if (!seen_bad) begin
                                obs  = smp;
                                want = exp_s;
                                if (smp !== exp_s) seen_bad = 1'b1;
                            end
                        end
                        if (aborted) break;
                        check($sformatf("lane%0d_bit%0d", g, b), 32'(obs), 32'(want));
                    end
                    if (!aborted) begin
                        @(negedge clk);
                        check($sformatf("lane%0d_tick_count", g), 32'(ticks), 32'(ef.nbits));
                        check($sformatf("lane%0d_frame_end", g),
                              32'({done_w[g], ready_w[g], busy_w[g], tx_w[g]}), 32'b1101);
                        chk_low = 1'b1;
                    end
                    prev = 1'b1;
                    continue;
                end
                prev = tx_w[g];
            end
        end
    end

    initial begin
        logic bad_done;
        for (int l = 0; l < 4; l++) drive(l, 8'h00, 1'b0);

        // Reset then idle
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("idle_c%0d", i),
                  32'({tx_w[0], ready_w[0], busy_w[0], done_w[0], baud_w[0]}), 32'b11000);
        end
        check("idle_default_lane", 32'({tx_w[3], ready_w[3], busy_w[3], done_w[3], baud_w[3]}), 32'b11000);

        // Single byte 0xA5, no parity
        exp_q[0].push_back(mk(12'({1'b1, 8'hA5, 1'b0}), 10, 0));
        drive(0, 8'hA5, 1'b1);
        wait_accept(0, "a5_accept");
        drive(0, 8'hA5, 1'b0);
        wait_done(0, 40, 100, "a5_done_latency");
        check("a5_ready_with_done", 32'(ready_w[0]), 32'd1);
        repeat (5) @(negedge clk);

        // Even and odd parity, 0x07 (three ones)
        exp_q[1].push_back(mk(12'({1'b1, 1'b1, 8'h07, 1'b0}), 11, 0));
        exp_q[2].push_back(mk(12'({1'b1, 1'b0, 8'h07, 1'b0}), 11, 0));
        drive(1, 8'h07, 1'b1);
        drive(2, 8'h07, 1'b1);
        wait_accept(1, "par_accept");
        drive(1, 8'h07, 1'b0);
        drive(2, 8'h07, 1'b0);
        wait_done(1, 44, 100, "par_even_done_latency");
        check("par_odd_done_same_cycle", 32'(done_w[2]), 32'd1);
        repeat (5) @(negedge clk);

        // Back-to-back with valid held high; data_in changes mid-frame
        exp_q[0].push_back(mk(12'({1'b1, 8'h00, 1'b0}), 10, 0));
        exp_q[0].push_back(mk(12'({1'b1, 8'hFF, 1'b0}), 10, 41));
        drive(0, 8'h00, 1'b1);
        wait_accept(0, "b2b_accept1");
        drive(0, 8'hFF, 1'b1);
        wait_ready(0, "b2b_ready");
        wait_accept(0, "b2b_accept2");
        drive(0, 8'h00, 1'b0);
        wait_done(0, 40, 100, "b2b_done2_latency");
        repeat (5) @(negedge clk);

        // Reset during data bit 3, then a fresh byte
        exp_q[0].push_back(mk(12'({1'b1, 8'h5A, 1'b0}), 10, 0));
        drive(0, 8'h5A, 1'b1);
        wait_accept(0, "rstmid_accept");
        drive(0, 8'h5A, 1'b0);
        repeat (18) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstmid_outputs", 32'({tx_w[0], ready_w[0], busy_w[0], done_w[0]}), 32'b1100);
        rst = 1'b0;
        bad_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done_w[0] !== 1'b0) bad_done = 1'b1;
        end
        check("rstmid_no_done", 32'(bad_done), 32'd0);
        exp_q[0].push_back(mk(12'({1'b1, 8'h3C, 1'b0}), 10, 0));
        drive(0, 8'h3C, 1'b1);
        wait_accept(0, "fresh_accept");
        drive(0, 8'h3C, 1'b0);
        wait_done(0, 40, 100, "fresh_done_latency");
        repeat (5) @(negedge clk);

        // Default parameters: 650 clocks per bit, byte 0x55
        exp_q[3].push_back(mk(12'({1'b1, 8'h55, 1'b0}), 10, 0));
        drive(3, 8'h55, 1'b1);
        wait_accept(3, "dflt_accept");
        drive(3, 8'h55, 1'b0);
        wait_done(3, 6500, 7000, "dflt_done_latency");
        repeat (5) @(negedge clk);

        for (int l = 0; l < 4; l++)
            check($sformatf("lane%0d_queue_drained", l), 32'(exp_q[l].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit-side UART controller that sequences one serial frame per accepted byte. Frame order is start bit, data bits LSB first, optional parity bit, then stop bit. Bit timing comes from an internal baud counter that reloads every CLKS_PER_BIT clocks; this replaces free-running clock_divider usage with an enable-style tick in the single system clock domain. The block sits between the byte source (host/FIFO side) and the tx pin.

Parameters:
CLKS_PER_BIT, 650, system clocks per serial bit; legal range is 2 or more.
DATA_BITS, 8, data bits per frame; legal range is 5 to 9.
PARITY, 0, 0 = none, 1 = even, 2 = odd.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
data_in  input  DATA_BITS  byte to send; sampled only on acceptance.
valid  input  1  source has data_in available.
ready  output  1  controller can accept; high only in IDLE.
tx  output  1  serial line; idles high.
busy  output  1  high while a frame is in progress (any state other than IDLE).
done  output  1  one-cycle pulse marking frame completion.
baud_tick  output  1  one-cycle pulse at the last clock of each bit period; low in IDLE.

Behaviour:
- Reset (rst=1 sampled at an edge): state=IDLE, tx=1, ready=1, busy=0, done=0, baud_tick=0, baud counter=0, bit counter=0, shift register=0.
- All outputs are registered or decoded from registered state; no combinational path from valid/data_in to tx.
- Acceptance: valid and ready both high at an edge. At that edge, data_in is latched into the shift register. Next state is START, with tx=0, ready=0, busy=1.
- Baud counter counts 0 to CLKS_PER_BIT-1 in every non-IDLE state. It wraps to 0 and pulses baud_tick when it reaches CLKS_PER_BIT-1. The counter is cleared on entry to each frame.
- States and transitions:
  - IDLE: tx=1. Go to START on acceptance.
  - START: tx=0 for CLKS_PER_BIT clocks. Go to DATA on tick.
  - DATA: tx = shift[0]. On each tick, shift right and increment the bit counter. After DATA_BITS ticks, go to PARITY if PARITY≠0, else go to STOP.
  - PARITY: tx = XOR of the latched data (even), or its inverse (odd), for one bit period. Go to STOP on tick.
  - STOP: tx=1 for one bit period. On tick, go to IDLE and assert done=1 for exactly one cycle.
- ready and done go high in the same cycle.
- Timing: the edge that returns to IDLE is N*CLKS_PER_BIT clocks after the acceptance edge, where N = DATA_BITS+2, plus 1 if PARITY≠0.
- Back-to-back: if valid is held high, the next byte is accepted one clock after done. Frame-to-frame period is N*CLKS_PER_BIT+1 clocks.
- Ignored inputs: valid and data_in are ignored while busy. A valid pulse during a frame is not queued.
- Reset mid-frame: takes effect at the next edge. tx returns to 1 immediately and the frame is abandoned. done is not pulsed.
- Counter widths: baud counter is clog2(CLKS_PER_BIT) bits; bit counter is clog2(DATA_BITS+1) bits. Neither counter may wrap past its terminal value.

Test Plan:
1. Reset then idle: hold rst for 3 cycles, then release for 20 cycles → tx=1, ready=1, busy=0, done=0, baud_tick=0 throughout.
2. Single byte, CLKS_PER_BIT=4, PARITY=0, data 0xA5 → tx reads 0,1,0,1,0,0,1,0,1,1, each level held 4 clocks. done pulses exactly 40 clocks after the acceptance edge, and ready rises in the same cycle.
3. Even and odd parity, CLKS_PER_BIT=4, data 0x07 → parity bit is 1 with PARITY=1 and 0 with PARITY=2. The frame is 11 bits (44 clocks).
4. Back-to-back, valid held high with bytes 0x00 then 0xFF, CLKS_PER_BIT=4 → the second start bit begins exactly 41 clocks after the first. data_in changes during frame 1 do not corrupt it.
5. Reset mid-frame: assert rst during data bit 3 → tx=1 and ready=1 at the next edge, no done pulse. A fresh byte 0x3C is then sent correctly.
6. Default parameters, CLKS_PER_BIT=650, data 0x55 → every bit is 650 clocks wide, and baud_tick fires 10 times per frame.
